// File: rtl/synt_cal_pkg.sv
// Shared definitions for the receive-synthesizer coarse-band calibration engine:
// controller state encoding and the default width/timing constants.
package synt_cal_pkg;

    localparam int BAND_W_DEF     = 4;
    localparam int CNT_W_DEF      = 8;
    localparam int WIN_CYC_DEF    = 8;
    localparam int SETTLE_CYC_DEF = 2;
    localparam int PU_SETTLE_DEF  = 8;

    typedef enum logic [3:0] {
        ST_OFF    = 4'd0,
        ST_PWRUP  = 4'd1,
        ST_IDLE   = 4'd2,
        ST_START  = 4'd3,
        ST_SETTLE = 4'd4,
        ST_MEAS   = 4'd5,
        ST_DECIDE = 4'd6,
        ST_FINE_A = 4'd7,
        ST_FINE_B = 4'd8,
        ST_LOCKED = 4'd9
    } cal_state_t;

endpackage

// File: rtl/synt_cal_fcnt.sv
// Windowed frequency counter: after a start strobe, counts VCO_PULSE over
// exactly WIN_CYC cycles. The count saturates at all-ones; done is high during
// the last window cycle, so count is final on the following cycle.
module synt_cal_fcnt
    import synt_cal_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int WIN_CYC = WIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pulse,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam int               WIN_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             active;
    logic [WIN_W-1:0] win;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic p);
        if (p && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    assign done = active && (win == WIN_LAST);

    // Window sequencing: a start strobe (re)opens a fresh window
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            win    <= '0;
        end else if (start) begin
            active <= 1'b1;
            win    <= '0;
        end else if (active) begin
            win <= win + WIN_W'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

    // Pulse accumulation, cleared on start and held once the window closes
    always_ff @(posedge clk) begin
        if (start) begin
            count <= '0;
        end else if (active) begin
            count <= sat_inc(count, pulse);
        end
    end

endmodule

// File: rtl/synt_cal_engine.sv
// Coarse-band SAR calibration engine for the receive synthesizer.
// Each trial applies a band code, waits for VCO settling, counts divided-VCO
// pulses over a fixed window and keeps the trial bit when the count is below
// the target. Optional macro SYNT_CAL_FINE_EN adds a final C vs C+1 comparison.
module synt_cal_engine
    import synt_cal_pkg::*;
#(
    parameter int BAND_W     = BAND_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WIN_CYC    = WIN_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int PU_SETTLE  = PU_SETTLE_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PU_SYNT,
    input  logic              CAL_SYNT,
    input  logic              VCO_PULSE,
    input  logic [CNT_W-1:0]  TARGET_CNT,
    output logic [BAND_W-1:0] BAND,
    output logic              RDY_SYNT,
    output logic              CAL_BUSY,
    output logic              CAL_ERR
);

    localparam logic [BAND_W-1:0] MID_CODE = {1'b1, {(BAND_W-1){1'b0}}};
    localparam int                IDX_W    = (BAND_W > 1) ? $clog2(BAND_W) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(BAND_W - 1);
    localparam int                TMR_MAX  = (PU_SETTLE > SETTLE_CYC) ? PU_SETTLE : SETTLE_CYC;
    localparam int                TMR_W    = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0]  PU_LAST  = TMR_W'(PU_SETTLE - 1);
    localparam logic [TMR_W-1:0]  SET_LAST = TMR_W'(SETTLE_CYC - 1);

    cal_state_t        state;
    cal_state_t        next;
    logic              cal_q;
    logic              pending;
    logic [TMR_W-1:0]  tmr;
    logic [BAND_W-1:0] band;
    logic [BAND_W-1:0] prev_band;
    logic [BAND_W-1:0] committed;
    logic [BAND_W-1:0] decided;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  target_q;
    logic [CNT_W-1:0]  count;
    logic              rdy;
    logic              busy;
    logic              err;
    logic              ctl_rst;
    logic              cal_rise;
    logic              cal_fall;
    logic              searching;
    logic              abort;
    logic              meas_start;
    logic              meas_done;
    logic              keep;
`ifdef SYNT_CAL_FINE_EN
    logic [1:0]        fine_ph;
    logic [CNT_W-1:0]  dev_c;
    logic [CNT_W-1:0]  dev_now;

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic signed [CNT_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? CNT_W'(-d) : CNT_W'(d);
    endfunction

    assign dev_now = abs_diff(count, target_q);
`endif

    function automatic logic [BAND_W-1:0] bit_mask(input logic [IDX_W-1:0] idx);
        return BAND_W'(1) << idx;
    endfunction

    // Power-down behaves exactly like reset for all control state
    assign ctl_rst    = RST | ~PU_SYNT;
    assign cal_rise   = CAL_SYNT & ~cal_q;
    assign cal_fall   = ~CAL_SYNT & cal_q;
    assign searching  = state inside {ST_SETTLE, ST_MEAS, ST_DECIDE, ST_FINE_A, ST_FINE_B};
    assign abort      = searching & cal_fall;
    assign meas_start = (state == ST_SETTLE) && (tmr == SET_LAST);
    // Higher code means higher frequency: a low count asks for a higher code
    assign keep       = count < target_q;
    assign decided    = keep ? band : committed;

    synt_cal_fcnt #(
        .CNT_W   (CNT_W),
        .WIN_CYC (WIN_CYC)
    ) u_fcnt (
        .clk   (CLK),
        .rst   (ctl_rst),
        .start (meas_start),
        .pulse (VCO_PULSE),
        .count (count),
        .done  (meas_done)
    );

    // Single register stage on CAL_SYNT for edge detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            cal_q <= 1'b0;
        end else begin
            cal_q <= CAL_SYNT;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (ctl_rst) begin
            state <= ST_OFF;
        end else begin
            state <= next;
        end
    end

    // FSM next-state logic; an abort overrides every search transition
    always_comb begin
        next = state;
        case (state)
            ST_OFF:    if (PU_SYNT) next = ST_PWRUP;
            ST_PWRUP:  if (tmr == PU_LAST) next = ST_IDLE;
            ST_IDLE,
            ST_LOCKED: if (cal_rise || pending) next = ST_START;
            ST_START:  next = ST_SETTLE;
            ST_SETTLE: if (tmr == SET_LAST) next = ST_MEAS;
            ST_MEAS: begin
                if (meas_done) begin
`ifdef SYNT_CAL_FINE_EN
                    case (fine_ph)
                        2'd1:    next = ST_FINE_A;
                        2'd2:    next = ST_FINE_B;
                        default: next = ST_DECIDE;
                    endcase
`else
                    next = ST_DECIDE;
`endif
                end
            end
            ST_DECIDE: begin
                if (bit_idx != '0) begin
                    next = ST_SETTLE;
                end else begin
`ifdef SYNT_CAL_FINE_EN
                    next = (decided == '1) ? ST_LOCKED : ST_SETTLE;
`else
                    next = ST_LOCKED;
`endif
                end
            end
            ST_FINE_A: next = ST_SETTLE;
            ST_FINE_B: next = ST_LOCKED;
            default:   next = ST_OFF;
        endcase
        if (abort) begin
            next = ST_IDLE;
        end
    end

    // Search datapath and registered status flags
    always_ff @(posedge CLK) begin
        if (ctl_rst) begin
            band    <= MID_CODE;
            rdy     <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            pending <= 1'b0;
            tmr     <= '0;
`ifdef SYNT_CAL_FINE_EN
            fine_ph <= 2'd0;
`endif
        end else begin
            if (next != state) begin
                tmr <= '0;
            end else if ((state == ST_PWRUP) || (state == ST_SETTLE)) begin
                tmr <= tmr + TMR_W'(1);
            end
            if (abort) begin
                band <= prev_band;
                err  <= 1'b1;
                busy <= 1'b0;
                rdy  <= 1'b0;
            end else begin
                case (state)
                    ST_PWRUP: if (cal_rise) pending <= 1'b1;
                    ST_IDLE,
                    ST_LOCKED: begin
                        if (next == ST_START) begin
                            prev_band <= band;
                            pending   <= 1'b0;
                            err       <= 1'b0;
                            rdy       <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    ST_START: begin
                        target_q  <= TARGET_CNT;
                        committed <= '0;
                        bit_idx   <= IDX_MSB;
                        band      <= MID_CODE;
`ifdef SYNT_CAL_FINE_EN
                        fine_ph   <= 2'd0;
`endif
                    end
                    ST_DECIDE: begin
                        committed <= decided;
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - IDX_W'(1);
                            band    <= decided | bit_mask(bit_idx - IDX_W'(1));
                        end else begin
                            band <= decided;
`ifdef SYNT_CAL_FINE_EN
                            if (decided == '1) begin
                                rdy  <= 1'b1;
                                busy <= 1'b0;
                            end else begin
                                fine_ph <= 2'd1;
                            end
`else
                            rdy  <= 1'b1;
                            busy <= 1'b0;
`endif
                        end
                    end
`ifdef SYNT_CAL_FINE_EN
                    ST_FINE_A: begin
                        dev_c   <= dev_now;
                        band    <= committed + BAND_W'(1);
                        fine_ph <= 2'd2;
                    end
                    ST_FINE_B: begin
                        // A tie keeps the SAR result
                        if (dev_now >= dev_c) begin
                            band <= committed;
                        end
                        rdy  <= 1'b1;
                        busy <= 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign BAND     = band;
    assign RDY_SYNT = rdy;
    assign CAL_BUSY = busy;
    assign CAL_ERR  = err;

endmodule
